// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int unsigned BOOTH_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth pair {Q[0], Q-1} decode
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational Booth step: adds, subtracts or passes the sign-extended
// multiplicand into the N+1-bit accumulator, before the arithmetic shift.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int unsigned N = BOOTH_N
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] m_i,
  input  logic [1:0]   pair_i,
  output logic [N:0]   a_o
);

  logic [N:0] m_ext;

  always_comb begin
    m_ext = {m_i[N-1], m_i};
    a_o   = a_i;
    case (pair_i)
      ADD:     a_o = a_i + m_ext;
      SUB:     a_o = a_i - m_ext;
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock, start/done handshake.
// Optional sticky start-while-busy flag `err` when BOOTH_ERR_EN is defined.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned N = BOOTH_N
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
`ifdef BOOTH_ERR_EN
  ,
  output logic           err
`endif
);

  localparam int unsigned CW = $clog2(N) + 1;

  state_t           state_q, state_d;
  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [N-1:0]     m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [N:0]       a_add;
  logic [N:0]       a_sh;
  logic [N-1:0]     q_sh;

  booth_addsub #(.N(N)) u_addsub (
    .a_i    (a_q),
    .m_i    (m_q),
    .pair_i ({q_q[0], qm1_q}),
    .a_o    (a_add)
  );

  // Arithmetic right shift of {A, Q, Q-1}; Q-1 takes the old Q[0]
  assign a_sh = {a_add[N], a_add[N:1]};
  assign q_sh = {a_add[0], q_q[N-1:1]};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          a_d     = '0;
          q_d     = mplier;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          product_d = {a_sh[N-1:0], q_sh};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);

`ifdef BOOTH_ERR_EN
    err_d = err_q | (start & ~ready_q);
`else
    err_d = 1'b0;
`endif
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;

`ifdef BOOTH_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: the driver pushes expected products,
// an independent monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned W2 = 2 * N;

  logic           clk;
  logic           clr;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           ready;
  logic           done;
  logic [W2-1:0]  product;
`ifdef BOOTH_ERR_EN
  logic           err;
`endif

  int checks = 0;
  int errors = 0;

  logic [W2-1:0] exp_q[$];
  logic [W2-1:0] prod_prev = '0;
  logic          done_prev = 1'b0;

  booth_mult_seq #(.N(N)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .ready   (ready),
    .done    (done),
    .product (product)
`ifdef BOOTH_ERR_EN
    ,
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer multiply truncated to 2N bits
  function automatic logic [W2-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return W2'(p);
  endfunction

  // Monitor: pops the scoreboard on done, enforces pulse width and product hold
  initial begin
    logic [W2-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!clr) begin
        if (done) begin
          if (exp_q.size() == 0) begin
            check("done_without_request", 64'(done), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("product", 64'(product), 64'(e));
          end
          check("done_pulse_width", 64'(done_prev), 64'd0);
        end else begin
          check("product_hold", 64'(product), 64'(prod_prev));
        end
      end
      done_prev = done;
      prod_prev = product;
    end
  end

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!ready && cyc < 4 * N) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_start", 64'(ready), 64'd1);
  endtask

  // One multiply with latency/ready checks; optional start pulse while busy
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W2-1:0] exp, input bit mid_start);
    bit seen;
    wait_ready();
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start  = 1'b0;
    mcand  = N'($urandom);
    mplier = N'($urandom);
    check("ready_after_accept", 64'(ready), 64'd0);
    seen = 1'b0;
    for (int k = 2; k <= 4 * N; k++) begin
      if (mid_start && k == 4) begin
        start  = 1'b1;
        mcand  = N'($urandom);
        mplier = N'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        check("latency", 64'(k), 64'(N + 1));
        seen = 1'b1;
        break;
      end
      check("ready_busy", 64'(ready), 64'd0);
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    @(negedge clk);
    check("ready_after_done", 64'(ready), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    int nacc, last_done;

    clr    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
`ifdef BOOTH_ERR_EN
    check("reset_err", 64'(err), 64'd0);
`endif
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed products
    run_op(8'd3,    8'd5,    16'h000F, 1'b0);
    run_op(8'hFD,   8'd5,    16'hFFF1, 1'b0);
    run_op(8'h80,   8'h80,   16'h4000, 1'b0);
    run_op(8'h7F,   8'h80,   16'hC080, 1'b0);
    run_op(8'h80,   8'h7F,   16'hC080, 1'b0);
    run_op(8'hFF,   8'hFF,   16'h0001, 1'b0);
`ifdef BOOTH_ERR_EN
    check("err_idle_clean", 64'(err), 64'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      run_op(a, b, model(a, b), 1'b0);
    end

    // Start pulse while busy must not disturb the running product
    a = N'($urandom);
    b = N'($urandom);
    run_op(a, b, model(a, b), 1'b1);
`ifdef BOOTH_ERR_EN
    check("err_set", 64'(err), 64'd1);
`endif
    run_op(8'd7, 8'hF9, 16'hFFCF, 1'b0);
`ifdef BOOTH_ERR_EN
    check("err_sticky", 64'(err), 64'd1);
`endif

    // start held high: one accept per N+2 cycles, busy-time operands ignored
    wait_ready();
    nacc      = 0;
    last_done = -1;
    for (int c = 0; c < 5 * (N + 2); c++) begin
      if (ready && nacc < 4) begin
        a      = N'($urandom);
        b      = N'($urandom);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        exp_q.push_back(model(a, b));
        nacc++;
      end else if (ready) begin
        start = 1'b0;
      end else begin
        mcand  = N'($urandom);
        mplier = N'($urandom);
      end
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) check("throughput", 64'(c - last_done), 64'(N + 2));
        last_done = c;
      end
    end
    start = 1'b0;

    // Abort during iteration 4: immediate reset values, no done afterwards
    wait_ready();
    mcand  = 8'h5A;
    mplier = 8'hC3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
`ifdef BOOTH_ERR_EN
    check("abort_err", 64'(err), 64'd0);
`endif
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    run_op(8'd0, 8'h55, 16'h0000, 1'b0);
    run_op(8'h55, 8'd0, 16'h0000, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
